// File: rtl/uart_phy.sv
// 8N1 UART line transceiver: TX serializer with one holding byte, RX deserializer
// oversampling uart_rxd at 16x with frame-relative sampling phase.
module uart_phy #(
  parameter int DIV = 15
) (
  input  logic       clk_bus,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_req,
  output logic       tx_full,
  output logic       tx_busy,
  output logic       tx_ovr,
  output logic [7:0] rx_data,
  output logic       rx_req,
  output logic       rx_ferr,
  output logic       uart_txd,
  input  logic       uart_rxd
);
  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

  // Reset asserts immediately but releases on a clock edge.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk_bus or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  tx_state_t   tx_state, tx_state_next;
  logic [15:0] tx_div;
  logic [3:0]  tx_os;
  logic [3:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic [7:0]  tx_hold;
  logic        tx_bit_end;
  logic        tx_load_new;
  logic        tx_load_hold;
  logic        tx_accept_hold;

  assign tx_bit_end     = (tx_div == DIV_LAST) && (tx_os == 4'd15);
  assign tx_accept_hold = tx_req && !tx_full && (tx_state != TX_IDLE) && !tx_load_new;
  assign tx_busy        = (tx_state != TX_IDLE) || tx_full;

  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) tx_state <= TX_IDLE;
    else        tx_state <= tx_state_next;
  end

  // A full hold register at the end of a stop bit chains the next frame with no idle gap.
  always_comb begin
    tx_state_next = tx_state;
    tx_load_new   = 1'b0;
    tx_load_hold  = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (tx_req) begin
          tx_state_next = TX_START;
          tx_load_new   = 1'b1;
        end
      end
      TX_START: if (tx_bit_end) tx_state_next = TX_DATA;
      TX_DATA:  if (tx_bit_end && (tx_bit == 4'd7)) tx_state_next = TX_STOP;
      TX_STOP: begin
        if (tx_bit_end) begin
          if (tx_full) begin
            tx_state_next = TX_START;
            tx_load_hold  = 1'b1;
          end else if (tx_req) begin
            tx_state_next = TX_START;
            tx_load_new   = 1'b1;
          end else begin
            tx_state_next = TX_IDLE;
          end
        end
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      tx_div   <= 16'd0;
      tx_os    <= 4'd0;
      tx_bit   <= 4'd0;
      tx_shift <= 8'h00;
      tx_hold  <= 8'h00;
      tx_full  <= 1'b0;
      tx_ovr   <= 1'b0;
      uart_txd <= 1'b1;
    end else begin
      tx_ovr <= tx_req && tx_full;
      if (tx_accept_hold) begin
        tx_hold <= tx_data;
        tx_full <= 1'b1;
      end
      if (tx_load_new || tx_load_hold) begin
        tx_shift <= tx_load_hold ? tx_hold : tx_data;
        if (tx_load_hold) tx_full <= 1'b0;
        uart_txd <= 1'b0;
        tx_div   <= 16'd0;
        tx_os    <= 4'd0;
        tx_bit   <= 4'd0;
      end else if (tx_state != TX_IDLE) begin
        if (tx_div == DIV_LAST) begin
          tx_div <= 16'd0;
          tx_os  <= tx_os + 4'd1;
        end else begin
          tx_div <= tx_div + 16'd1;
        end
        if (tx_bit_end) begin
          case (tx_state)
            TX_START: uart_txd <= tx_shift[0];
            TX_DATA: begin
              if (tx_bit == 4'd7) begin
                uart_txd <= 1'b1;
              end else begin
                uart_txd <= tx_shift[1];
                tx_shift <= {1'b0, tx_shift[7:1]};
                tx_bit   <= tx_bit + 4'd1;
              end
            end
            default: uart_txd <= 1'b1;
          endcase
        end
      end
    end
  end

  rx_state_t   rx_state, rx_state_next;
  logic        rx_meta;
  logic        rxs;
  logic [15:0] rx_div;
  logic [3:0]  rx_os;
  logic [3:0]  rx_bit;
  logic [7:0]  rx_shift;
  logic        rx_tick;
  logic        rx_clear;
  logic        rx_sample;
  logic        rx_stop_sample;

  assign rx_tick = (rx_div == DIV_LAST);

  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) rx_state <= RX_IDLE;
    else        rx_state <= rx_state_next;
  end

  // Counters are cleared on the start edge and again at mid start bit, so later
  // samples land every 16 ticks from the centre of the start bit.
  always_comb begin
    rx_state_next  = rx_state;
    rx_clear       = 1'b0;
    rx_sample      = 1'b0;
    rx_stop_sample = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (!rxs) begin
          rx_state_next = RX_START;
          rx_clear      = 1'b1;
        end
      end
      RX_START: begin
        if (rx_tick && (rx_os == 4'd7)) begin
          rx_clear      = 1'b1;
          rx_state_next = rxs ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_tick && (rx_os == 4'd15)) begin
          rx_sample = 1'b1;
          if (rx_bit == 4'd7) rx_state_next = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_tick && (rx_os == 4'd15)) begin
          rx_stop_sample = 1'b1;
          rx_state_next  = rxs ? RX_IDLE : RX_BREAK;
        end
      end
      RX_BREAK: if (rxs) rx_state_next = RX_IDLE;
      default:  rx_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_bus or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta  <= 1'b1;
      rxs      <= 1'b1;
      rx_div   <= 16'd0;
      rx_os    <= 4'd0;
      rx_bit   <= 4'd0;
      rx_shift <= 8'h00;
      rx_data  <= 8'h00;
      rx_req   <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_meta <= uart_rxd;
      rxs     <= rx_meta;
      rx_req  <= 1'b0;
      rx_ferr <= 1'b0;
      if (rx_clear) begin
        rx_div <= 16'd0;
        rx_os  <= 4'd0;
        rx_bit <= 4'd0;
      end else if ((rx_state != RX_IDLE) && (rx_state != RX_BREAK)) begin
        if (rx_tick) begin
          rx_div <= 16'd0;
          rx_os  <= rx_os + 4'd1;
        end else begin
          rx_div <= rx_div + 16'd1;
        end
      end
      if (rx_sample) begin
        rx_shift <= {rxs, rx_shift[7:1]};
        rx_bit   <= rx_bit + 4'd1;
      end
      if (rx_stop_sample) begin
        if (rxs) begin
          rx_data <= rx_shift;
          rx_req  <= 1'b1;
        end else begin
          rx_ferr <= 1'b1;
        end
      end
    end
  end

endmodule
